// File: rtl/wide_adder_pkg.sv
// Shared types for the sequential wide adder: FSM state encoding.
package wide_adder_pkg;
  localparam int WIDE_ADD_STATE_W = 2;

  typedef enum logic [WIDE_ADD_STATE_W-1:0] {
    IDLE,
    ADD,
    DONE
  } wide_add_state_t;
endpackage

// File: rtl/adder_nbit.sv
// BIT_WIDTH-bit ripple adder with carry in/out; the one datapath adder.
module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 cout
);
  // Widen to BIT_WIDTH+1 so the top bit carries out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, cin};
endmodule

// File: rtl/wide_adder_seq.sv
// Sequential multi-word adder: one BIT_WIDTH word per clock through a
// single adder_nbit, carry chained through a register.
// Optional self-checks compiled in with WIDE_ADDER_CHECK_EN.
module wide_adder_seq
  import wide_adder_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] op_a,
  input  logic [BIT_WIDTH*NUM_WORDS-1:0] op_b,
  input  logic                           carry_in,
  output logic                           busy,
  output logic                           done,
  output logic [BIT_WIDTH*NUM_WORDS-1:0] result,
  output logic                           carry_out
);
  localparam int W     = BIT_WIDTH * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  wide_add_state_t state, state_nxt;

  logic [W-1:0]         op_a_reg, op_b_reg, result_reg;
  logic                 carry_reg;
  logic [IDX_W-1:0]     idx;
  logic                 last_word;
  logic [BIT_WIDTH-1:0] word_a, word_b, word_sum;
  logic                 word_cout;

  assign last_word = (idx == LAST_IDX);
  assign word_a    = op_a_reg[idx*BIT_WIDTH +: BIT_WIDTH];
  assign word_b    = op_b_reg[idx*BIT_WIDTH +: BIT_WIDTH];
  assign result    = result_reg;
  assign carry_out = carry_reg;

  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_adder (
    .a   (word_a),
    .b   (word_b),
    .cin (carry_reg),
    .sum (word_sum),
    .cout(word_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and status outputs; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = ADD;
      ADD: begin
        busy = 1'b1;
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: snapshot operands on accept, then one word per ADD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      idx        <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_a_reg   <= op_a;
          op_b_reg   <= op_b;
          carry_reg  <= carry_in;
          idx        <= '0;
          result_reg <= '0;
        end
        ADD: begin
          result_reg[idx*BIT_WIDTH +: BIT_WIDTH] <= word_sum;
          carry_reg <= word_cout;
          // Hold idx on the last word so it never wraps mid-operation.
          if (!last_word) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef WIDE_ADDER_CHECK_EN
  // carry_reg is consumed by the chain, so keep the original carry-in.
  logic carry_in_chk;

  // Input sanity on accept and end-to-end sum check in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_in_chk <= 1'b0;
    end else if (state == IDLE && start) begin
      carry_in_chk <= carry_in;
      if ($isunknown(op_a))     $error("X/Z on input 'op_a'");
      if ($isunknown(op_b))     $error("X/Z on input 'op_b'");
      if ($isunknown(carry_in)) $error("X/Z on input 'carry_in'");
    end else if (state == DONE) begin
      assert ({carry_reg, result_reg} ==
              ({1'b0, op_a_reg} + {1'b0, op_b_reg} + (W+1)'(carry_in_chk)))
        else $error("Output 'result' is not correct");
    end
  end
`endif
endmodule

// File: tb/tb_wide_adder_seq.sv
// Randomized self-checking bench for wide_adder_seq (BIT_WIDTH=4, NUM_WORDS=4).
module tb_wide_adder_seq;
  localparam int BW = 4;
  localparam int NW = 4;
  localparam int W  = BW * NW;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         carry_in;
  logic         busy, done, carry_out;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  wide_adder_seq #(.BIT_WIDTH(BW), .NUM_WORDS(NW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; inputs are scrambled during ADD to prove the
  // snapshot, and poke also raises start with op_a=FFFF while busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit poke);
    logic [W:0] exp;
    exp      = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    op_a     = a;
    op_b     = b;
    carry_in = ci;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      chk("busy_add", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      carry_in = 1'($urandom);
      if (poke) begin
        start = 1'b1;
        op_a  = '1;
      end
      tick();
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(exp[W-1:0]));
    chk("carry_out", 32'(carry_out), 32'(exp[W]));
    tick();
    chk("done_single", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("result_hold", 32'(result), 32'(exp[W-1:0]));
    chk("carry_hold", 32'(carry_out), 32'(exp[W]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_done, pulses, seen_done;
    logic [W:0] exp;

    // Reset held with start asserted: nothing may start.
    rst      = 1'b1;
    start    = 1'b1;
    op_a     = 16'h1234;
    op_b     = 16'h4321;
    carry_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_carry", 32'(carry_out), 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Directed cases.
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b1);

    // Reset in the second ADD cycle abandons the operation.
    op_a = 16'h1234; op_b = 16'h1111; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", 32'(result), 32'h0);
    chk("midrst_carry", 32'(carry_out), 32'd0);
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) seen_done = 1;
      tick();
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 24; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);

    // Start held high: done every NW+2 cycles with the same answer.
    op_a = 16'hBEEF; op_b = 16'h4242; carry_in = 1'b1;
    exp  = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(carry_in);
    start     = 1'b1;
    last_done = -1;
    pulses    = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (last_done >= 0 && i == last_done + 1)
        chk("b2b_hold", 32'(result), 32'(exp[W-1:0]));
      if (done) begin
        if (last_done >= 0) chk("b2b_period", 32'(i - last_done), 32'(NW + 2));
        else                chk("b2b_first", 32'(i), 32'(NW + 1));
        chk("b2b_result", 32'(result), 32'(exp[W-1:0]));
        chk("b2b_carry", 32'(carry_out), 32'(exp[W]));
        last_done = i;
        pulses++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(pulses), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wide_adder_seq.md
# wide_adder_seq

Sequential multi-word adder that adds two `BIT_WIDTH*NUM_WORDS`-bit operands one `BIT_WIDTH`-bit word per clock. It reuses a single `adder_nbit` instance, feeding it one word pair per cycle, chaining the carry through a register, and collecting each word's sum. It sits directly around `adder_nbit`: it supplies the operands and carry-in upstream and captures sum and carry-out downstream. Width is traded for cycles.

## Interface
- `BIT_WIDTH`, default 4: word width, which is also the width of the `adder_nbit` instance.
- `NUM_WORDS`, default 4, minimum 1: number of words per operand. Total width is `W = BIT_WIDTH*NUM_WORDS`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new addition. Sampled only in IDLE.
- `op_a`  in  W: operand A. Word 0 is bits `[BIT_WIDTH-1:0]`.
- `op_b`  in  W: operand B.
- `carry_in`  in  1: carry into word 0.
- `busy`  out  1: high while in ADD state.
- `done`  out  1: one-cycle pulse; `result` and `carry_out` are final while it is high.
- `result`  out  W: registered sum.
- `carry_out`  out  1: registered carry out of the top word.

## Operation
- FSM has three states: IDLE, ADD, DONE.
- IDLE:
  - On `start=1`, latch `op_a`, `op_b` into operand registers.
  - Load the carry register with `carry_in`.
  - Clear the word index to 0 and clear `result` to 0.
  - Go to ADD.
- ADD, each cycle:
  - Drive `adder_nbit` with word[idx] of A, word[idx] of B, and the carry register.
  - Write the adder sum into result word[idx].
  - Load the carry register from the adder carry-out.
  - Increment idx.
  - When idx = `NUM_WORDS-1` is processed, go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE unconditionally.
- `carry_out` is a continuous view of the carry register, so it is final in DONE.
- Arithmetic: `{carry_out, result} = op_a + op_b + carry_in`, computed modulo 2^(W+1). No saturation.
- Operands are snapshotted at start. Changes on `op_a`, `op_b`, `carry_in` after the start cycle have no effect.
- `start` is ignored in ADD and DONE. There is no queuing.
- `result` and `carry_out` hold their values from DONE through IDLE until the next accepted `start`.
- idx width is `$clog2(NUM_WORDS)`, with a minimum of 1 bit. idx does not wrap within an operation.

## Timing
- Reset values:
  - FSM state = IDLE.
  - `busy=0`, `done=0`, `result=0`, `carry_out=0`.
  - Operand registers, carry register, and idx are all 0.
- Reset wins over every other event in the same cycle, including `start` and DONE.
- Reset mid-ADD: the operation is abandoned, no `done` is produced, and all outputs take their reset values at that edge.
- Latency: if `start` is sampled at edge E0, `busy` is high for the NUM_WORDS cycles after E0. `done` is high in the cycle after edge E0+NUM_WORDS.
- Throughput: if `start` is held high continuously, a new operation is accepted every `NUM_WORDS+2` cycles.
- Combinational path per cycle is one `adder_nbit` ripple of BIT_WIDTH bits, from register to register.

## Configuration
- `WIDE_ADDER_CHECK_EN` defined:
  - At start acceptance, assert `op_a`, `op_b`, `carry_in` contain no X/Z, reporting via `$error` with the offending port name.
  - In DONE, assert `{carry_out, result} == op_a_reg + op_b_reg + carry_in_reg`, using a captured copy of `carry_in`; otherwise `$error("Output 'result' is not correct")`.
  - Any check-only registers are compiled in only under this macro.
- Undefined: no assertions and no extra registers. Functional behaviour is identical.

## Structure
- Package `wide_adder_pkg`:
  - `typedef enum logic [1:0] {IDLE, ADD, DONE} wide_add_state_t`.
  - localparam `WIDE_ADD_STATE_W = 2`.
- Sub-module: exactly one `adder_nbit #(.BIT_WIDTH(BIT_WIDTH))` instance, the datapath adder.
- Word select and result write are done with indexed part-select `[idx*BIT_WIDTH +: BIT_WIDTH]`.

## Test plan
All scenarios use BIT_WIDTH=4, NUM_WORDS=4, so W=16.
- Reset: hold `rst` for 2 cycles with `start=1` -> `busy=0`, `done=0`, `result=16'h0000`, `carry_out=0`, and no operation starts.
- Basic: `op_a=16'h00FF`, `op_b=16'h0001`, `carry_in=0`, start at E0 -> `busy` high for 4 cycles, `done` pulse after E0+4, `result=16'h0100`, `carry_out=0`.
- Full ripple: `op_a=16'hFFFF`, `op_b=16'h0000`, `carry_in=1` -> `result=16'h0000`, `carry_out=1`. Also check `16'h8000 + 16'h8000` -> `result=0`, `carry_out=1`.
- Ignored start and operand snapshot: start `1234+1111`, then pulse `start` with `op_a=16'hFFFF` during ADD and change `op_a` mid-operation -> a single `done` with `result=16'h2345`.
- Reset mid-operation: assert `rst` in the 2nd ADD cycle -> next cycle `busy=0`, `result=0`, and no `done` ever appears. A following start of `0001+0001` yields `result=16'h0002`.
- Back-to-back: hold `start=1` with a fixed operand pair -> `done` pulses exactly every 6 cycles and `result` is stable between pulses.
